// File: rtl/rr_arb_mux.sv
// rr_arb_mux
//   Registered N:1 arbitrating multiplexer. Each cycle in which the output
//   register can load, one requesting input channel is selected (round-robin
//   or fixed priority). Its word and its channel index are captured in the
//   output register. Valid/ready handshakes on every input and on the output.
//
// Parameters
//   N      number of input channels (2..64)
//   WIDTH  data bits per channel (>= 1)
//   MODE   0 = round-robin starting at ptr, 1 = fixed priority (lowest index)
//   SW     channel index width, derived from N
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   [N]        channel i presents a word
//   in_data    [N*WIDTH]  channel i word at [i*WIDTH +: WIDTH]
//   in_ready   [N]        channel i word accepted this cycle (one-hot or zero)
//   out_valid             output register holds a word
//   out_data   [WIDTH]    registered selected word
//   out_sel    [SW]       channel that supplied out_data
//   out_ready             consumer takes out_data this cycle
module rr_arb_mux #(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = 0,
  localparam int SW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] chan_data [N];
  logic [SW-1:0]    ptr;
  logic [SW-1:0]    base;
  logic [SW:0]      sum;
  logic [SW-1:0]    win;
  logic             found;
  logic             load;
  logic [N-1:0]     grant;
  logic [SW-1:0]    ptr_next;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SW-1:0]    sel_p1;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign chan_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  // The output register may take a new word when it is empty or being drained.
  assign load = !vld_p1 || out_ready;

  // Search order starts at base and wraps modulo N. The sum carries one extra
  // bit so the wrap subtraction works for non-power-of-2 N and every candidate
  // index stays below N. Only in_valid and ptr feed this, never in_data.
  always_comb begin
    base  = (MODE == 1) ? '0 : ptr;
    sum   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, base} + (SW+1)'(k);
      if (sum >= (SW+1)'(N)) sum = sum - (SW+1)'(N);
      if (!found && in_valid[sum[SW-1:0]]) begin
        found = 1'b1;
        win   = sum[SW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (rst_n && load && found) grant[win] = 1'b1;
  end

  assign in_ready = grant;

  // Wrap explicitly at N-1 so ptr never reaches N for non-power-of-2 N.
  assign ptr_next = (win == SW'(N-1)) ? '0 : win + 1'b1;

  // Stage p0 -> p1: selected word and index captured in the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (found) begin
        vld_p1  <= 1'b1;
        data_p1 <= chan_data[win];
        sel_p1  <= win;
        if (MODE == 0) ptr <= ptr_next;
        else           ptr <= '0;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule
